// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_mc_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUB_B      = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // States that sit on the unified memory and may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// Latency: none (wires only).
// Backpressure: mem_ready from the memory stalls the sequencer in memory states.
interface mc_control_fsm_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic               instr_done;
  logic               fault;
  logic [1:0]         fault_code;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, fault, fault_code, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, fault, fault_code, state
  );
endinterface

// File: rtl/mc_control_fsm_wait_timer.sv
// Counts consecutive memory stall cycles and flags a timeout at MAX_WAIT.
// Latency: counter registered; timeout is combinational from count and i_wait.
// Backpressure: none; MAX_WAIT=0 disables the timeout entirely.
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_timeout
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Saturating stall counter, cleared whenever the sequencer changes state.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_wait && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = (MAX_WAIT != 0) && i_wait && (r_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/mem/writeback; MC_ADDI_EN adds addi.
// Latency (mem_ready high): R=4, lw=5, sw=4, beq=3, j=3, addi=4 cycles.
// Backpressure: holds FETCH/MEM_RD/MEM_WR until mem_ready; stall of MAX_WAIT+1 cycles faults.
module mc_control_fsm
  import mips_mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int STATE_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  mc_control_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_fault_code;
  logic [1:0] w_fault_code;
  logic       w_mem_wait;
  logic       w_timeout;

  assign w_mem_wait = is_mem_state(r_state) && !bus.mem_ready;

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_next != r_state),
    .i_wait    (w_mem_wait),
    .o_timeout (w_timeout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Fault code latches only on entry to FAULT, so the first cause sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_code <= FC_NONE;
    end else if ((r_state != S_FAULT) && (w_next == S_FAULT)) begin
      r_fault_code <= w_fault_code;
    end
  end

  // Next-state and Moore output decode; strobes are killed while rst is high.
  always_comb begin
    w_next            = r_state;
    w_fault_code      = FC_NONE;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = ALUB_B;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_source     = PCSRC_ALU;
    bus.instr_done    = 1'b0;
    bus.fault         = 1'b0;

    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALUB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = FC_TIMEOUT;
        end else if (bus.mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = ALUB_IMM_SH;
        case (bus.opcode)
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = S_ADDI_EX;
`endif
          default: begin
            w_next       = S_FAULT;
            w_fault_code = FC_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUB_IMM;
        w_next        = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = FC_TIMEOUT;
        end else if (bus.mem_ready) begin
          w_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = FC_TIMEOUT;
        end else if (bus.mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
        w_next        = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.pc_write_cond = 1'b1;
        bus.instr_done    = 1'b1;
        w_next            = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_source  = PCSRC_JUMP;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUB_IMM;
        w_next        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = S_FETCH;
      end
`endif
      default: begin
        // FAULT and every unused encoding: absorbing, no strobes.
        bus.fault    = 1'b1;
        w_next       = S_FAULT;
        w_fault_code = FC_ILLEGAL;
      end
    endcase

    if (rst) begin
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.reg_write     = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.ir_write      = 1'b0;
      bus.instr_done    = 1'b0;
    end
  end

  assign bus.fault_code = r_fault_code;
  assign bus.state      = STATE_W'(r_state);

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational control unit when the datapath is refactored to share one ALU and one unified memory across instruction phases. It steps each instruction through fetch/decode/execute/memory/writeback states and drives every datapath mux and write enable. It waits on a memory ready handshake and traps illegal opcodes and memory timeouts.

Parameters:
MAX_WAIT, 15, max consecutive cycles with mem_ready low in a memory state before fault; 0 disables the timeout
STATE_W, 4, state register width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], held stable by the datapath after FETCH
mem_ready  input  1  memory completed the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by ALU zero (externally ANDed)
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  writeback select: 1=MDR, 0=ALUOut
reg_dst  output  1  write register select: 1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A register
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump address
instr_done  output  1  last cycle of an instruction
fault  output  1  sticky fault flag
fault_code  output  2  01=illegal opcode, 10=memory timeout, 00=none
state  output  STATE_W  current state, for debug

Behaviour:
- Reset: synchronous, active-high. On the clk edge with rst=1: state=FETCH, wait counter=0, fault=0, fault_code=00. While rst=1, mem_read, mem_write, reg_write, pc_write, pc_write_cond, ir_write and instr_done are forced 0 regardless of state. Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, FAULT=15.
- Outputs are Moore-decoded from state. Exceptions: ir_write, pc_write (FETCH) and instr_done (MEM_WR) are gated by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Goes to DECODE on mem_ready, else stays.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> see Optional Feature
  - any other -> FAULT, code 01
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, else MEM_WR.
- MEM_RD: mem_read=1, iord=1. Goes to MEM_WB on mem_ready.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, iord=1, instr_done=mem_ready. Goes to FETCH on mem_ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1. Goes to FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1. Goes to FETCH.
- FAULT: all strobes 0, fault=1. Absorbing until rst.
- Wait counter (ceil(log2(MAX_WAIT+1)) bits, saturating):
  - Clears on every state change.
  - Increments each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - If the counter equals MAX_WAIT and mem_ready=0 with MAX_WAIT≠0, the next state is FAULT with code 10.
  - mem_ready=1 in the same cycle wins over the timeout.
- Latency with mem_ready tied high: R=4, lw=5, sw=4, beq=3, j=3, addi=4 cycles.
- fault_code is written only on entry to FAULT. The first fault wins.

Optional Feature:
MC_ADDI_EN.
- Defined: opcode 001000 goes DECODE -> ADDI_EX -> ADDI_WB -> FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1.
- Undefined: opcode 001000 is illegal and goes to FAULT with code 01. States 10/11 are unreachable and decode as FAULT.

Decomposition:
- Package mips_mc_pkg holds:
  - state encodings (localparams above)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_src_b, alu_op and pc_source encodings
  - fault code constants
- Sub-module mc_wait_timer (counter + timeout compare, parameter MAX_WAIT) is natural. The FSM and output decode stay in mc_control_fsm.

Test Plan:
- rst=1 for 2 cycles, then opcode=000000, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and instr_done=1 only in state 7.
- opcode=100011, mem_ready low 3 cycles in MEM_RD -> states 0,1,2,3,3,3,3,4,0; mem_read=1 and iord=1 throughout MEM_RD.
- opcode=000100 -> in state 8: pc_write_cond=1, pc_source=01, alu_op=01; back to FETCH next cycle.
- opcode=111111 -> FAULT after DECODE; fault=1, fault_code=01; all strobes 0 for 10 cycles; rst returns to FETCH with fault=0.
- MAX_WAIT=4, mem_ready=0 in FETCH -> FAULT entered after the 5th wait cycle, fault_code=10. Repeat with mem_ready=1 on the 5th cycle -> DECODE, no fault.
- opcode=001000: with MC_ADDI_EN -> states 0,1,10,11,0 and reg_write=1 in 11; without it -> fault_code=01.
